upc_flow_sequencer: RTL and testbench
=====================================

Name: upc_flow_sequencer

Overview:
Program-flow sequencer for the uPC core. It owns the program counter and a parametrised hardware return stack. It executes the flow-control opcodes (conditional and unconditional jump, call, return) that the combinational opcode decoder only flags. It sits between instruction fetch (drives the fetch address) and the decoder/ALU flags (consumes opcode, branch target and zero flag).

Parameters:
- PC_W, 8, program counter and branch target width in bits (4..16).
- STACK_DEPTH, 4, number of return-address entries (1..16).
- SP_W, $clog2(STACK_DEPTH+1), stack-level counter width; derived, not overridden.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- step  in  1  advance enable; 1 = consume current opcode this cycle, 0 = hold all state.
- opcode  in  4  current instruction opcode.
- target  in  PC_W  branch/call destination from the instruction immediate.
- zero_flag  in  1  ALU zero flag used by conditional jumps.
- clear_err  in  1  clears sticky error flags.
- pc  out  PC_W  current fetch address (registered).
- stack_level  out  SP_W  number of valid return entries (registered).
- stack_full  out  1  stack_level == STACK_DEPTH.
- stack_empty  out  1  stack_level == 0.
- err_overflow  out  1  sticky; a CALL was issued with the stack full.
- err_underflow  out  1  sticky; a RET was issued with the stack empty.

Behaviour:
- Reset (synchronous, wins over all inputs): pc=0, stack_level=0, err_overflow=0, err_underflow=0, stack_empty=1, stack_full=0. Stack contents are don't-care.
- step=0: pc, stack and level hold. clear_err still acts.
- Opcode map, evaluated only when step=1:
  - JZ 4'b1000: pc<=target if zero_flag=1, else pc+1.
  - JNZ 4'b1001: pc<=target if zero_flag=0, else pc+1.
  - JMP 4'b1010: pc<=target.
  - RET 4'b1100 or 4'b1101: if not empty, pc<=top entry and level decrements; if empty, pc<=pc+1, err_underflow<=1, level unchanged.
  - CALL 4'b1110: if not full, push pc+1, pc<=target, level increments; if full, pc<=pc+1, err_overflow<=1, no push.
  - All other opcodes: pc<=pc+1.
- Arithmetic: pc+1 is modulo 2^PC_W. Max value wraps to 0, including the pushed return address.
- Latency: one cycle. The new pc is visible on the clock edge following the opcode with step=1.
- The stack is LIFO. The top entry is the most recent push. Entries above the level are never read.
- stack_full and stack_empty are decoded combinationally from the registered level and are consistent with it every cycle.
- Error flags stay set until reset or clear_err=1. If clear_err and a new error event occur in the same cycle, the error event wins and the flag stays 1.
- Back-to-back CALL/RET on consecutive step cycles are fully supported, with no bubble.

Decomposition:
- Package upc_pkg holds the opcode localparams OP_JZ, OP_JNZ, OP_JMP, OP_RET0, OP_RET1, OP_CALL, shared with the decoder.
- Sub-module upc_return_stack is a parametrised LIFO register array. Ports: push, pop, din, top, level, full, empty. It ignores push-when-full and pop-when-empty.
- The sequencer holds the pc register, next-pc mux and error logic.

Test Plan:
- Reset then 3 NOP steps (opcode 4'b0001) -> pc=3, stack_empty=1, no errors.
- pc=5, CALL target=0x40 -> pc=0x40, level=1. Then RET -> pc=6, level=0.
- JZ target=0x20 with zero_flag=1 -> pc=0x20. JZ with zero_flag=0 from pc=0x20 -> pc=0x21. JNZ covered symmetrically.
- STACK_DEPTH=4: five CALLs -> level=4, stack_full=1, err_overflow=1, 5th CALL advances pc by 1. Four RETs return in reverse push order. A 5th RET sets err_underflow, pc+1.
- PC_W=8, pc=0xFF: NOP -> pc=0x00. CALL at 0xFF pushes 0x00, RET returns to 0x00.
- step=0 for 3 cycles with CALL on opcode -> no change. Reset asserted mid-sequence with level=2 -> pc=0, level=0 next edge. clear_err with simultaneous overflow -> err_overflow stays 1.

Source files
------------

// File: rtl/upc_pkg.sv
// Shared opcode encodings for the uPC flow-control instructions.
package upc_pkg;

  localparam logic [3:0] OP_JZ   = 4'b1000;
  localparam logic [3:0] OP_JNZ  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1010;
  localparam logic [3:0] OP_RET0 = 4'b1100;
  localparam logic [3:0] OP_RET1 = 4'b1101;
  localparam logic [3:0] OP_CALL = 4'b1110;

  // True for either return encoding.
  function automatic logic is_ret(input logic [3:0] op);
    return (op == OP_RET0) || (op == OP_RET1);
  endfunction

endpackage

// File: rtl/upc_return_stack.sv
// Parametrised LIFO of return addresses. Push-when-full and pop-when-empty
// are silently ignored; the caller is responsible for flagging them.
module upc_return_stack
  import upc_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    top,
  output logic [SP_W-1:0] level,
  output logic            full,
  output logic            empty
);

  logic [W-1:0]    mem_r [DEPTH];
  logic [SP_W-1:0] level_r;
  logic [SP_W-1:0] top_idx_s;
  logic [W-1:0]    top_s;
  logic            full_s;
  logic            empty_s;

  // Flag decode and top-of-stack select from the registered level.
  always_comb begin
    full_s    = (level_r == SP_W'(DEPTH));
    empty_s   = (level_r == SP_W'(1'b0));
    top_idx_s = level_r - SP_W'(1'b1);
    top_s     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      top_s = top_s | (((SP_W'(i) == top_idx_s) && !empty_s) ? mem_r[i] : W'(1'b0));
    end
  end

  // Level counter: one step up on an accepted push, one down on an accepted pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      level_r <= '0;
    end else if (push && !full_s) begin
      level_r <= level_r + SP_W'(1'b1);
    end else if (pop && !empty_s) begin
      level_r <= level_r - SP_W'(1'b1);
    end else begin
      level_r <= level_r;
    end
  end

  // Entry storage: written at the current level on an accepted push; contents need no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && !full_s && (SP_W'(i) == level_r)) begin
        mem_r[i] <= din;
      end
    end
  end

  assign top   = top_s;
  assign level = level_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/upc_flow_sequencer.sv
// Program-flow sequencer: owns the program counter, executes jump/call/return
// and keeps sticky stack overflow/underflow flags.
module upc_flow_sequencer
  import upc_pkg::*;
#(
  parameter  int PC_W        = 8,
  parameter  int STACK_DEPTH = 4,
  localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            step,
  input  logic [3:0]      opcode,
  input  logic [PC_W-1:0] target,
  input  logic            zero_flag,
  input  logic            clear_err,
  output logic [PC_W-1:0] pc,
  output logic [SP_W-1:0] stack_level,
  output logic            stack_full,
  output logic            stack_empty,
  output logic            err_overflow,
  output logic            err_underflow
);

  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_next_s;
  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] stack_top_s;
  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            pop_s;
  logic            ovf_evt_s;
  logic            unf_evt_s;
  logic            err_overflow_r;
  logic            err_underflow_r;

  upc_return_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH),
    .SP_W  (SP_W)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (pc_inc_s),
    .top   (stack_top_s),
    .level (stack_level),
    .full  (full_s),
    .empty (empty_s)
  );

  // Next-pc mux plus stack control and error events for the current opcode.
  always_comb begin
    pc_inc_s  = pc_r + PC_W'(1'b1);
    pc_next_s = pc_r;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    ovf_evt_s = 1'b0;
    unf_evt_s = 1'b0;
    if (step) begin
      case (opcode)
        OP_JZ:   pc_next_s = zero_flag ? target : pc_inc_s;
        OP_JNZ:  pc_next_s = zero_flag ? pc_inc_s : target;
        OP_JMP:  pc_next_s = target;
        OP_RET0,
        OP_RET1: begin
          if (empty_s) begin
            pc_next_s = pc_inc_s;
            unf_evt_s = 1'b1;
          end else begin
            pc_next_s = stack_top_s;
            pop_s     = 1'b1;
          end
        end
        OP_CALL: begin
          if (full_s) begin
            pc_next_s = pc_inc_s;
            ovf_evt_s = 1'b1;
          end else begin
            pc_next_s = target;
            push_s    = 1'b1;
          end
        end
        default: pc_next_s = pc_inc_s;
      endcase
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Program counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r <= '0;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // Sticky error flags: a new event beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_overflow_r  <= 1'b0;
      err_underflow_r <= 1'b0;
    end else begin
      if (ovf_evt_s) begin
        err_overflow_r <= 1'b1;
      end else if (clear_err) begin
        err_overflow_r <= 1'b0;
      end else begin
        err_overflow_r <= err_overflow_r;
      end
      if (unf_evt_s) begin
        err_underflow_r <= 1'b1;
      end else if (clear_err) begin
        err_underflow_r <= 1'b0;
      end else begin
        err_underflow_r <= err_underflow_r;
      end
    end
  end

  assign pc            = pc_r;
  assign stack_full    = full_s;
  assign stack_empty   = empty_s;
  assign err_overflow  = err_overflow_r;
  assign err_underflow = err_underflow_r;

endmodule

// File: tb/tb_upc_flow_sequencer.sv
// Self-checking bench for upc_flow_sequencer: directed scenarios followed by
// random opcode streams, all compared against a queue-based reference model.
module tb_upc_flow_sequencer;

  localparam int PC_W  = 8;
  localparam int DEPTH = 4;
  localparam int SP_W  = $clog2(DEPTH + 1);

  logic            clock = 1'b0;
  logic            reset;
  logic            step;
  logic [3:0]      opcode;
  logic [PC_W-1:0] target;
  logic            zero_flag;
  logic            clear_err;
  logic [PC_W-1:0] pc;
  logic [SP_W-1:0] stack_level;
  logic            stack_full;
  logic            stack_empty;
  logic            err_overflow;
  logic            err_underflow;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_pc;
  int m_stk[$];
  bit m_eo;
  bit m_eu;

  always #5 clock = ~clock;

  upc_flow_sequencer #(
    .PC_W        (PC_W),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .step          (step),
    .opcode        (opcode),
    .target        (target),
    .zero_flag     (zero_flag),
    .clear_err     (clear_err),
    .pc            (pc),
    .stack_level   (stack_level),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the rules of the instruction set.
  task automatic model_step(input bit s, input int op, input int t, input bit z, input bit c, input bit r);
    bit ov;
    bit un;
    int nxt;
    ov  = 1'b0;
    un  = 1'b0;
    nxt = (m_pc + 1) % (1 << PC_W);
    if (r) begin
      m_pc = 0;
      m_stk.delete();
      m_eo = 1'b0;
      m_eu = 1'b0;
    end else begin
      if (s) begin
        if (op == 8)               m_pc = z ? t : nxt;
        else if (op == 9)          m_pc = z ? nxt : t;
        else if (op == 10)         m_pc = t;
        else if (op == 12 || op == 13) begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin un = 1'b1; m_pc = nxt; end
        end else if (op == 14) begin
          if (m_stk.size() < DEPTH) begin m_stk.push_back(nxt); m_pc = t; end
          else begin ov = 1'b1; m_pc = nxt; end
        end else                   m_pc = nxt;
      end
      m_eo = ov ? 1'b1 : (c ? 1'b0 : m_eo);
      m_eu = un ? 1'b1 : (c ? 1'b0 : m_eu);
    end
  endtask

  // Drive one cycle, update the model at the edge, then compare all outputs.
  task automatic cyc(input bit s, input int op, input int t, input bit z, input bit c, input bit r);
    step      = s;
    opcode    = 4'(op);
    target    = PC_W'(t);
    zero_flag = z;
    clear_err = c;
    reset     = r;
    @(posedge clock);
    model_step(s, op, t, z, c, r);
    #1;
    check("pc",    32'(pc),            32'(m_pc));
    check("level", 32'(stack_level),   32'(m_stk.size()));
    check("full",  32'(stack_full),    32'(m_stk.size() == DEPTH));
    check("empty", 32'(stack_empty),   32'(m_stk.size() == 0));
    check("ovf",   32'(err_overflow),  32'(m_eo));
    check("unf",   32'(err_underflow), 32'(m_eu));
  endtask

  task automatic op1(input int op, input int t, input bit z);
    cyc(1'b1, op, t, z, 1'b0, 1'b0);
  endtask

  initial begin
    m_pc = 0;
    m_eo = 1'b0;
    m_eu = 1'b0;

    // Reset and NOP stepping
    cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_empty", 32'(stack_empty), 32'd1);
    for (int i = 0; i < 3; i++) op1(1, 0, 1'b0);
    check("nop3_pc", 32'(pc), 32'd3);

    // Call / return
    op1(10, 5, 1'b0);
    op1(14, 8'h40, 1'b0);
    check("call_pc", 32'(pc), 32'h40);
    check("call_lvl", 32'(stack_level), 32'd1);
    op1(12, 0, 1'b0);
    check("ret_pc", 32'(pc), 32'd6);

    // Conditional jumps
    op1(8, 8'h20, 1'b1);
    check("jz_taken", 32'(pc), 32'h20);
    op1(8, 8'h50, 1'b0);
    check("jz_not", 32'(pc), 32'h21);
    op1(9, 8'h30, 1'b0);
    check("jnz_taken", 32'(pc), 32'h30);
    op1(9, 8'h60, 1'b1);
    check("jnz_not", 32'(pc), 32'h31);

    // Overflow then underflow
    for (int i = 1; i <= 5; i++) op1(14, i * 16, 1'b0);
    check("ovf_full", 32'(stack_full), 32'd1);
    check("ovf_flag", 32'(err_overflow), 32'd1);
    check("ovf_pc", 32'(pc), 32'h41);
    op1(13, 0, 1'b0);
    check("ret1_pc", 32'(pc), 32'h31);
    for (int i = 0; i < 3; i++) op1(12, 0, 1'b0);
    check("ret4_pc", 32'(pc), 32'h32);
    op1(12, 0, 1'b0);
    check("unf_flag", 32'(err_underflow), 32'd1);
    check("unf_pc", 32'(pc), 32'h33);
    cyc(1'b0, 14, 0, 1'b0, 1'b1, 1'b0);
    check("clr_stepless", 32'(err_overflow), 32'd0);

    // Wrap at the top of the address space
    op1(10, 8'hFF, 1'b0);
    op1(1, 0, 1'b0);
    check("wrap_pc", 32'(pc), 32'd0);
    op1(10, 8'hFF, 1'b0);
    op1(14, 8'h80, 1'b0);
    op1(12, 0, 1'b0);
    check("wrap_ret", 32'(pc), 32'd0);

    // Hold with step=0
    op1(10, 8'h12, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 14, 8'h77, 1'b0, 1'b0, 1'b0);
    check("hold_pc", 32'(pc), 32'h12);
    check("hold_lvl", 32'(stack_level), 32'd0);

    // Reset mid-sequence
    op1(14, 8'h20, 1'b0);
    op1(14, 8'h30, 1'b0);
    cyc(1'b1, 14, 8'h40, 1'b0, 1'b0, 1'b1);
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_lvl", 32'(stack_level), 32'd0);

    // Clear coinciding with a fresh overflow
    for (int i = 0; i < 5; i++) op1(14, 8'h10, 1'b0);
    cyc(1'b1, 14, 8'h10, 1'b0, 1'b1, 1'b0);
    check("clr_vs_ovf", 32'(err_overflow), 32'd1);

    // Random streams biased toward stack traffic
    for (int n = 0; n < 800; n++) begin
      int op;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 3)      op = 14;
      else if (sel < 6) op = 12 + $urandom_range(0, 1);
      else              op = $urandom_range(0, 15);
      cyc(($urandom_range(0, 7) != 0), op, $urandom_range(0, 255),
          1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 60) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
